dma_ping_pong_buffer: RTL and testbench
=======================================

# dma_ping_pong_buffer

Two-bank ping-pong word buffer directly upstream of the DMA write engine. A producer (the JTAG capture path) streams 32-bit words into the fill bank. When that bank is full or flushed, it is handed to the DMA, and `data_ready` is raised. The DMA reads the held bank by address and releases it. Meanwhile the producer keeps filling the other bank.

## Interface
- `DEPTH_LOG2`, default 4: bank depth is DEPTH = 2^DEPTH_LOG2 words (16).
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  producer write strobe; ignored while `full`=1.
- `push_data`  in  32  word written with `push`.
- `flush`  in  1  single-cycle pulse; requests handover of a partially filled bank.
- `full`  out  1  producer must not push; combinational from state registers.
- `overflow`  out  1  sticky: set when a push was attempted while `full`=1; cleared only by reset.
- `data_ready`  out  1  a bank is held for the DMA.
- `word_count`  out  DEPTH_LOG2+1  number of valid words in the held bank (1..DEPTH); 0 when not held.
- `pop_en`  in  1  DMA read strobe.
- `pop_address`  in  DEPTH_LOG2  word index within the held bank.
- `pop_data`  out  32  registered read data.
- `release`  in  1  single-cycle pulse; the DMA is finished with the held bank.

## Operation
- State registers:
  - `fill_bank` (1 bit): bank currently receiving pushes.
  - `fill_count` (0..DEPTH): words written into the fill bank.
  - `held` (1 bit): the other bank belongs to the DMA.
  - `held_count`: word count latched at handover.
  - `flush_pending` (1 bit): sticky flush request.
- Storage: 2×DEPTH×32 register array. Contents are not cleared by reset.
- Handover condition `ho` = !held && (fill_count==DEPTH || (flush_pending && fill_count!=0)).
- `full` = (fill_count==DEPTH) || ho. Pushes are blocked during the handover cycle.
- Accepted push (push && !full): mem[fill_bank][fill_count[DEPTH_LOG2-1:0]] <= push_data; fill_count++.
- On `ho`, in the next state:
  - held=1, held_count=fill_count, fill_bank toggles, fill_count=0, flush_pending=0.
- `flush` sets flush_pending.
  - If fill_count==0 and no push is accepted in the same cycle, the flush is discarded and flush_pending stays 0.
  - A flush in the same cycle as an accepted push is retained and hands over on a later cycle.
- `release` while held: held=0 and held_count=0 next cycle. `release` while !held is ignored.
- Simultaneous release and a pending handover condition: release takes effect first. `ho` is evaluated on the next cycle (no same-cycle re-hold).
- Fill bank full while held: `full` stays 1 until release, then handover occurs one cycle after release.
- `data_ready` = held and `word_count` = held_count, both driven directly from registers.
- Read: on pop_en, pop_data <= mem[~fill_bank][pop_address]; otherwise pop_data holds its value. pop_address ≥ held_count returns stale bank contents (not checked).
- `overflow` <= 1 on push && full.

## Timing
- Reset (reset=0, asynchronous) forces:
  - fill_bank=0, fill_count=0, held=0, held_count=0, flush_pending=0.
  - full=0, overflow=0, data_ready=0, word_count=0, pop_data=0.
- Reset mid-transfer discards both banks' bookkeeping. The DMA must treat data_ready falling as an abort.
- Push acceptance: 0-cycle decision, word stored at the edge.
- The DEPTH-th push at edge N → `full`=1 after edge N; handover at edge N+1; data_ready=1 and full=0 after edge N+1. A new push is accepted after edge N+1.
- Flush: pulse at edge N (fill_count>0, !held) → flush_pending after N → data_ready=1 after N+1.
- pop_data latency: one cycle (address at edge N, data valid after edge N).
- release at edge N → data_ready=0 after N.

## Test plan
- Reset then 16 pushes of 0x100..0x10F → full=1 for one cycle, data_ready=1, word_count=16. Pop addresses 0..15 return 0x100..0x10F, one cycle after each address.
- 5 pushes (0xA0..0xA4), then flush → data_ready=1 two cycles after flush, word_count=5. A flush with fill_count==0 produces no data_ready.
- Held bank not released while 16 more pushes (0x200..0x20F) arrive → full stays 1. A 17th push sets overflow=1. release → data_ready drops, re-rises next cycle with word_count=16 and data 0x200..0x20F.
- Flush and an accepted push in the same cycle with fill_count==3 → handover with word_count=4. release while !held → no effect.
- Asynchronous reset asserted mid-drain (held=1, fill_count=7) → all outputs 0 immediately, overflow cleared, the next 16 pushes fill bank 0.

Source files
------------

// File: rtl/dma_ping_pong_buffer.sv
// Two-bank ping-pong word buffer between the JTAG capture producer and the DMA write engine.
// One bank fills while the other is held for the DMA to read by address and release.
module dma_ping_pong_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [31:0]           push_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  overflow,
  output logic                  data_ready,
  output logic [DEPTH_LOG2:0]   word_count,
  input  logic                  pop_en,
  input  logic [DEPTH_LOG2-1:0] pop_address,
  output logic [31:0]           pop_data,
  // 'release' is a reserved word, so the DMA release pulse carries a suffix.
  input  logic                  release_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic                  fill_bank_q, fill_bank_d;
  logic [DEPTH_LOG2:0]   fill_count_q, fill_count_d;
  logic                  held_q, held_d;
  logic [DEPTH_LOG2:0]   held_count_q, held_count_d;
  logic                  flush_pending_q, flush_pending_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           pop_data_q, pop_data_d;
  logic [31:0]           mem_q [2*DEPTH];

  logic                  fill_is_full;
  logic                  handover;
  logic                  push_accept;
  logic [DEPTH_LOG2:0]   wr_idx;
  logic [DEPTH_LOG2:0]   rd_idx;

  // A bank is handed over when it is full, or when a flush is pending on a non-empty bank,
  // but only once the DMA has given the other bank back.
  assign fill_is_full = (fill_count_q == FULL_COUNT);
  assign handover     = !held_q && (fill_is_full || (flush_pending_q && (fill_count_q != '0)));
  assign full         = fill_is_full || handover;
  assign push_accept  = push && !full;

  assign wr_idx = {fill_bank_q, fill_count_q[DEPTH_LOG2-1:0]};
  assign rd_idx = {~fill_bank_q, pop_address};

  always_comb begin
    fill_bank_d     = fill_bank_q;
    fill_count_d    = fill_count_q;
    held_d          = held_q;
    held_count_d    = held_count_q;
    flush_pending_d = flush_pending_q;
    overflow_d      = overflow_q | (push & full);
    pop_data_d      = pop_data_q;

    if (handover) begin
      held_d          = 1'b1;
      held_count_d    = fill_count_q;
      fill_bank_d     = ~fill_bank_q;
      fill_count_d    = '0;
      flush_pending_d = 1'b0;
    end else begin
      if (push_accept) begin
        fill_count_d = fill_count_q + COUNT_ONE;
      end
      // A flush on an empty bank is dropped unless a word lands in the same cycle.
      if (flush && ((fill_count_q != '0) || push_accept)) begin
        flush_pending_d = 1'b1;
      end
    end

    // Handover requires !held, so this never collides with the handover branch above.
    if (held_q && release_i) begin
      held_d       = 1'b0;
      held_count_d = '0;
    end

    if (pop_en) begin
      pop_data_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_bank_q     <= 1'b0;
      fill_count_q    <= '0;
      held_q          <= 1'b0;
      held_count_q    <= '0;
      flush_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      pop_data_q      <= '0;
    end else begin
      fill_bank_q     <= fill_bank_d;
      fill_count_q    <= fill_count_d;
      held_q          <= held_d;
      held_count_q    <= held_count_d;
      flush_pending_q <= flush_pending_d;
      overflow_q      <= overflow_d;
      pop_data_q      <= pop_data_d;
    end
  end

  // Storage keeps its contents across reset; only the bookkeeping is cleared.
  always_ff @(posedge clock) begin
    if (push_accept) begin
      mem_q[wr_idx] <= push_data;
    end
  end

  assign overflow   = overflow_q;
  assign data_ready = held_q;
  assign word_count = held_count_q;
  assign pop_data   = pop_data_q;

endmodule

// File: tb/tb_dma_ping_pong_buffer.sv
// Directed bench for dma_ping_pong_buffer: a vector table for fill/flush/drain, then
// hand-written sequences for back-pressure, overflow, same-cycle flush+push and async reset.
module tb_dma_ping_pong_buffer;

  logic        clock;
  logic        reset;
  logic        push;
  logic [31:0] push_data;
  logic        flush;
  logic        full;
  logic        overflow;
  logic        data_ready;
  logic [4:0]  word_count;
  logic        pop_en;
  logic [3:0]  pop_address;
  logic [31:0] pop_data;
  logic        release_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  dma_ping_pong_buffer #(.DEPTH_LOG2(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .push_data   (push_data),
    .flush       (flush),
    .full        (full),
    .overflow    (overflow),
    .data_ready  (data_ready),
    .word_count  (word_count),
    .pop_en      (pop_en),
    .pop_address (pop_address),
    .pop_data    (pop_data),
    .release_i   (release_i)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        push;
    logic [31:0] data;
    logic        flush;
    logic        pop_en;
    logic [3:0]  addr;
    logic        rel;
    logic        e_full;
    logic        e_ovf;
    logic        e_ready;
    logic [4:0]  e_wc;
    logic        chk_pop;
    logic [31:0] e_pop;
  } vec_t;

  localparam int NVEC = 46;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic p, input logic [31:0] d, input logic f,
                              input logic pe, input logic [3:0] a, input logic r,
                              input logic ef, input logic er, input logic [4:0] ewc,
                              input logic cp, input logic [31:0] ep);
    vec_t v;
    v.push = p; v.data = d; v.flush = f; v.pop_en = pe; v.addr = a; v.rel = r;
    v.e_full = ef; v.e_ovf = 1'b0; v.e_ready = er; v.e_wc = ewc;
    v.chk_pop = cp; v.e_pop = ep;
    return v;
  endfunction

  // Driver tasks: inputs change after the sample point, outputs are checked 1 time unit past the edge.
  task automatic cycle(input logic p, input logic [31:0] d, input logic f,
                       input logic pe, input logic [3:0] a, input logic r);
    push = p; push_data = d; flush = f; pop_en = pe; pop_address = a; release_i = r;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic push_word(input logic [31:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic pop_at(input logic [3:0] a);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic do_release();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  // Scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_status(input string name, input logic ef, input logic eo,
                              input logic er, input logic [4:0] ewc);
    check({name, ".full"},       {31'b0, full},       {31'b0, ef});
    check({name, ".overflow"},   {31'b0, overflow},   {31'b0, eo});
    check({name, ".data_ready"}, {31'b0, data_ready}, {31'b0, er});
    check({name, ".word_count"}, {27'b0, word_count}, {27'b0, ewc});
  endtask

  task automatic check_pop(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=0x%0h", name, pop_data);
    end else begin
      e = exp_q.pop_front();
      check(name, pop_data, e);
    end
  endtask

  initial begin
    // Table: 16-word fill, handover, full drain, release, 5-word flush, partial drain.
    for (int i = 0; i < 16; i++)
      vecs[i] = mk(1'b1, 32'h100 + i, 1'b0, 1'b0, 4'h0, 1'b0, (i == 15), 1'b0, 5'd0, 1'b0, 32'h0);
    vecs[16] = mk(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0, 32'h0);
    for (int j = 0; j < 16; j++)
      vecs[17 + j] = mk(1'b0, 32'h0, 1'b0, 1'b1, 4'(j), 1'b0, 1'b0, 1'b1, 5'd16, 1'b1, 32'h100 + j);
    vecs[33] = mk(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++)
      vecs[34 + k] = mk(1'b1, 32'hA0 + k, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    vecs[39] = mk(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0);
    vecs[40] = mk(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++)
      vecs[41 + k] = mk(1'b0, 32'h0, 1'b0, 1'b1, 4'(k), 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 32'hA0 + k);

    reset = 1'b0;
    push = 1'b0; push_data = '0; flush = 1'b0; pop_en = 1'b0; pop_address = '0; release_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_status("reset", 1'b0, 1'b0, 1'b0, 5'd0);
    check("reset.pop_data", pop_data, 32'h0);
    #3 reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].push, vecs[i].data, vecs[i].flush, vecs[i].pop_en, vecs[i].addr, vecs[i].rel);
      check_status($sformatf("vec%0d", i), vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_ready, vecs[i].e_wc);
      if (vecs[i].chk_pop) check($sformatf("vec%0d.pop_data", i), pop_data, vecs[i].e_pop);
    end

    // Flush on an empty, unheld fill bank must not create a handover or a pending flush.
    do_release();
    check_status("rel_a", 1'b0, 1'b0, 1'b0, 5'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0);
    check_status("empty_flush", 1'b0, 1'b0, 1'b0, 5'd0);
    repeat (2) idle();
    check_status("empty_flush_later", 1'b0, 1'b0, 1'b0, 5'd0);
    push_word(32'h55);
    check_status("after_empty_flush_push", 1'b0, 1'b0, 1'b0, 5'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0);
    check_status("flush_one", 1'b1, 1'b0, 1'b0, 5'd0);
    idle();
    check_status("flush_one_held", 1'b0, 1'b0, 1'b1, 5'd1);
    pop_at(4'd0);
    check("flush_one.pop", pop_data, 32'h55);
    do_release();
    check_status("rel_b", 1'b0, 1'b0, 1'b0, 5'd0);

    // Back-pressure: second bank fills while the first is held, then overflow, then re-hold.
    for (int i = 0; i < 16; i++) push_word(32'h300 + i);
    check_status("fill_300", 1'b1, 1'b0, 1'b0, 5'd0);
    idle();
    check_status("held_300", 1'b0, 1'b0, 1'b1, 5'd16);
    for (int i = 0; i < 16; i++) begin
      push_word(32'h200 + i);
      exp_q.push_back(32'h200 + i);
    end
    check_status("fill_200", 1'b1, 1'b0, 1'b1, 5'd16);
    repeat (2) idle();
    check_status("full_while_held", 1'b1, 1'b0, 1'b1, 5'd16);
    push_word(32'hDEAD);
    check_status("overflow_push", 1'b1, 1'b1, 1'b1, 5'd16);
    pop_at(4'd0);
    check("held_300.pop0", pop_data, 32'h300);
    pop_at(4'd15);
    check("held_300.pop15", pop_data, 32'h30F);
    do_release();
    check_status("rel_full", 1'b1, 1'b1, 1'b0, 5'd0);
    idle();
    check_status("rehold_200", 1'b0, 1'b1, 1'b1, 5'd16);
    for (int i = 0; i < 16; i++) begin
      pop_at(4'(i));
      check_pop($sformatf("drain_200[%0d]", i));
    end

    // Flush in the same cycle as an accepted push at fill_count==3.
    do_release();
    check_status("rel_c", 1'b0, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) push_word(32'h40 + i);
    cycle(1'b1, 32'h43, 1'b1, 1'b0, 4'h0, 1'b0);
    check_status("flush_push", 1'b1, 1'b1, 1'b0, 5'd0);
    idle();
    check_status("held_4", 1'b0, 1'b1, 1'b1, 5'd4);
    pop_at(4'd3);
    check("held_4.pop3", pop_data, 32'h43);
    idle();
    check("pop_hold", pop_data, 32'h43);
    pop_at(4'd0);
    check("held_4.pop0", pop_data, 32'h40);
    do_release();
    check_status("rel_d", 1'b0, 1'b1, 1'b0, 5'd0);
    do_release();
    check_status("rel_unheld", 1'b0, 1'b1, 1'b0, 5'd0);

    // Asynchronous reset while a bank is held and the fill bank holds 7 words.
    for (int i = 0; i < 16; i++) push_word(32'h500 + i);
    idle();
    for (int i = 0; i < 7; i++) push_word(32'h600 + i);
    pop_at(4'd2);
    check_status("pre_reset", 1'b0, 1'b1, 1'b1, 5'd16);
    check("pre_reset.pop", pop_data, 32'h502);
    #2 reset = 1'b0;
    #1;
    check_status("async_reset", 1'b0, 1'b0, 1'b0, 5'd0);
    check("async_reset.pop_data", pop_data, 32'h0);
    #2 reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_word(32'h700 + i);
      exp_q.push_back(32'h700 + i);
    end
    check_status("post_reset_fill", 1'b1, 1'b0, 1'b0, 5'd0);
    idle();
    check_status("post_reset_held", 1'b0, 1'b0, 1'b1, 5'd16);
    for (int i = 0; i < 16; i++) begin
      pop_at(4'(i));
      check_pop($sformatf("drain_700[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
